// File: rtl/ram_dp_port_arbiter.sv
// Round-robin arbiter sharing one true dual-port RAM between NREQ requesters.
// Optional statistics counters are enabled with `define RAM_ARB_STATS_EN.
module ram_dp_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic               weA,
  output logic               weB,
  output logic [AW-1:0]      addrA,
  output logic [AW-1:0]      addrB,
  output logic [DW-1:0]      dinA,
  output logic [DW-1:0]      dinB,
  input  logic [DW-1:0]      doutA,
  input  logic [DW-1:0]      doutB
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]        stat_conflicts,
  output logic [15:0]        stat_grants
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] scan_idx [NREQ];
  logic [NREQ-1:0] scan_valid;
  logic [IW-1:0] win_a, win_b, last_idx;
  logic has_a, has_b, we_a, we_b, conflict, grant_a, grant_b;
  logic [AW-1:0] addr_a, addr_b, addr_a_hold_reg, addr_b_hold_reg;
  logic [DW-1:0] din_a, din_b, din_a_hold_reg, din_b_hold_reg;
  logic tag_a_valid_reg, tag_b_valid_reg;
  logic [IW-1:0] tag_a_id_reg, tag_b_id_reg;

  // Rotated view of the requesters: position gi holds index (rr_ptr + gi) mod NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
    logic [IW:0] sum;
    assign sum = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
    assign scan_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
    assign scan_valid[gi] = req_valid[scan_idx[gi]];
  end

  always_comb begin
    has_a = 1'b0;
    has_b = 1'b0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (scan_valid[k]) begin
        if (!has_a) begin
          has_a = 1'b1;
          win_a = scan_idx[k];
        end else if (!has_b) begin
          has_b = 1'b1;
          win_b = scan_idx[k];
        end
      end
    end
  end

  assign we_a   = req_we[win_a];
  assign we_b   = req_we[win_b];
  assign addr_a = req_addr[win_a*AW +: AW];
  assign addr_b = req_addr[win_b*AW +: AW];
  assign din_a  = req_wdata[win_a*DW +: DW];
  assign din_b  = req_wdata[win_b*DW +: DW];

  // A blocked B is simply dropped this cycle; no further candidate is searched.
  assign conflict = has_a && has_b && (addr_a == addr_b) && (we_a || we_b);
  assign grant_a  = rst_n && has_a;
  assign grant_b  = rst_n && has_b && !conflict;
  assign last_idx = grant_b ? win_b : win_a;

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[win_a] = 1'b1;
    if (grant_b) req_ready[win_b] = 1'b1;
  end

  assign weA   = grant_a && we_a;
  assign weB   = grant_b && we_b;
  assign addrA = grant_a ? addr_a : addr_a_hold_reg;
  assign addrB = grant_b ? addr_b : addr_b_hold_reg;
  assign dinA  = grant_a ? din_a : din_a_hold_reg;
  assign dinB  = grant_b ? din_b : din_b_hold_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg      <= '0;
      tag_a_valid_reg <= 1'b0;
      tag_b_valid_reg <= 1'b0;
      tag_a_id_reg    <= '0;
      tag_b_id_reg    <= '0;
      addr_a_hold_reg <= '0;
      addr_b_hold_reg <= '0;
      din_a_hold_reg  <= '0;
      din_b_hold_reg  <= '0;
    end else begin
      if (grant_a || grant_b)
        rr_ptr_reg <= (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
      tag_a_valid_reg <= grant_a && !we_a;
      tag_b_valid_reg <= grant_b && !we_b;
      tag_a_id_reg    <= win_a;
      tag_b_id_reg    <= win_b;
      if (grant_a) begin
        addr_a_hold_reg <= addr_a;
        din_a_hold_reg  <= din_a;
      end
      if (grant_b) begin
        addr_b_hold_reg <= addr_b;
        din_b_hold_reg  <= din_b;
      end
    end
  end

  // Response tags line up with RAM output data one cycle after the grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    logic hit_a, hit_b;
    logic [DW-1:0] rdata_hold_reg;
    assign hit_a = rst_n && tag_a_valid_reg && (tag_a_id_reg == IW'(gi));
    assign hit_b = rst_n && tag_b_valid_reg && (tag_b_id_reg == IW'(gi));
    assign rsp_valid[gi] = hit_a || hit_b;
    assign rsp_rdata[gi*DW +: DW] = hit_a ? doutA : (hit_b ? doutB : rdata_hold_reg);
    always_ff @(posedge clk) begin
      if (!rst_n) rdata_hold_reg <= '0;
      else        rdata_hold_reg <= rsp_rdata[gi*DW +: DW];
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [16:0] grant_sum;
  assign grant_sum = {1'b0, stat_grants} + 17'(grant_a) + 17'(grant_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
      stat_grants    <= '0;
    end else begin
      if (conflict && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      stat_grants <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Table-driven bench for ram_dp_port_arbiter with a behavioural dual-port RAM and
// a read-response scoreboard; define RAM_ARB_STATS_EN to also check the counters.
module tb_ram_dp_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mem_init;
  logic [N-1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, dinB, doutA, doutB;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_grants;
`endif

  ram_dp_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RAM_ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_grants(stat_grants),
`endif
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .doutA(doutA), .doutB(doutB)
  );

  // Behavioural RAM: registered address capture, read data one cycle later.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'(i * 7 + 3);
    end else begin
      if (weA) ram[addrA] <= dinA;
      if (weB) ram[addrB] <= dinB;
    end
    doutA <= ram[addrA];
    doutB <= ram[addrB];
  end

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [39:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   rdy;
    logic         wea;
    logic         web;
    logic [9:0]   aa;
    logic [9:0]   ab;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } sb_t;

  vec_t tv [20];
  sb_t sb [$];
  logic [31:0] ref_mem [1024];
  logic [127:0] exp_rdata;
  int rcnt [4];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w,
                              input int a0, input int a1, input int a2, input int a3,
                              input int d0, input int d1, input int d2, input int d3,
                              input logic [3:0] r, input logic wa, input logic wb,
                              input int aa, input int ab);
    vec_t m;
    m.valid = v;
    m.we    = w;
    m.addr  = {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    m.wdata = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
    m.rdy   = r;
    m.wea   = wa;
    m.web   = wb;
    m.aa    = 10'(aa);
    m.ab    = 10'(ab);
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input vec_t v);
    logic [3:0] exp_valid;
    logic [9:0] a;
    sb_t e;
    req_valid = v.valid;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    #1;
    chk("req_ready", req_ready, v.rdy);
    chk("weA", weA, v.wea);
    chk("weB", weB, v.web);
    chk("addrA", addrA, v.aa);
    chk("addrB", addrB, v.ab);
    exp_valid = '0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      exp_valid[e.id] = 1'b1;
      exp_rdata[e.id*32 +: 32] = e.data;
    end
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    for (int i = 0; i < 4; i++) if (rsp_valid[i]) rcnt[i]++;
    for (int i = 0; i < 4; i++) begin
      if (v.rdy[i]) begin
        a = v.addr[i*10 +: 10];
        if (v.we[i]) begin
          ref_mem[a] = v.wdata[i*32 +: 32];
        end else begin
          e.id   = 2'(i);
          e.data = ref_mem[a];
          e.due  = cyc + 1;
          sb.push_back(e);
        end
      end
    end
    $display("[TB] step %0d valid=%b we=%b ready=%b weA=%b weB=%b rsp_valid=%b",
             cyc, v.valid, v.we, req_ready, weA, weB, rsp_valid);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int exp_grants;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i * 7 + 3);
    for (int i = 0; i < 4; i++) rcnt[i] = 0;
    exp_rdata = '0;

    tv[0]  = mk(4'b0001, 4'b0001, 510, 0, 0, 0, 1020, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 510, 0);
    tv[1]  = mk(4'b0001, 4'b0000, 510, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 1'b0, 1'b0, 510, 0);
    tv[2]  = mk(4'b0110, 4'b0110, 0, 10, 20, 0, 0, 1245, 2124, 0, 4'b0110, 1'b1, 1'b1, 10, 20);
    tv[3]  = mk(4'b0110, 4'b0000, 0, 10, 20, 0, 0, 0, 0, 0, 4'b0110, 1'b0, 1'b0, 10, 20);
    tv[4]  = mk(4'b0011, 4'b0001, 5, 5, 0, 0, 7, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 5, 20);
    tv[5]  = mk(4'b0010, 4'b0000, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0010, 1'b0, 1'b0, 5, 20);
    tv[6]  = mk(4'b1000, 4'b1000, 0, 0, 0, 100, 0, 0, 0, 333, 4'b1000, 1'b1, 1'b0, 100, 20);
    tv[7]  = mk(4'b1111, 4'b0000, 200, 201, 202, 203, 0, 0, 0, 0, 4'b0011, 1'b0, 1'b0, 200, 201);
    tv[8]  = mk(4'b1111, 4'b0000, 200, 201, 202, 203, 0, 0, 0, 0, 4'b1100, 1'b0, 1'b0, 202, 203);
    tv[9]  = mk(4'b1111, 4'b0000, 200, 201, 202, 203, 0, 0, 0, 0, 4'b0011, 1'b0, 1'b0, 200, 201);
    tv[10] = mk(4'b1111, 4'b0000, 200, 201, 202, 203, 0, 0, 0, 0, 4'b1100, 1'b0, 1'b0, 202, 203);
    tv[11] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 202, 203);
    tv[12] = mk(4'b0100, 4'b0100, 0, 0, 1023, 0, 0, 0, 5555, 0, 4'b0100, 1'b1, 1'b0, 1023, 203);
    tv[13] = mk(4'b0100, 4'b0000, 0, 0, 1023, 0, 0, 0, 0, 0, 4'b0100, 1'b0, 1'b0, 1023, 203);
    tv[14] = mk(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1'b0, 1'b0, 0, 203);
    tv[15] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 0, 203);
    tv[16] = mk(4'b0011, 4'b0000, 5, 5, 0, 0, 0, 0, 0, 0, 4'b0011, 1'b0, 1'b0, 5, 5);
    tv[17] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 5, 5);
    tv[18] = mk(4'b1111, 4'b0000, 400, 401, 402, 403, 0, 0, 0, 0, 4'b0011, 1'b0, 1'b0, 400, 401);
    tv[19] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 400, 401);

    // Reset with every requester asking: nothing may be granted or returned.
    rst_n = 1'b0;
    mem_init = 1'b1;
    req_valid = 4'b1111;
    req_we = 4'b0000;
    req_addr = '0;
    req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_weA", weA, 1'b0);
    chk("rst_weB", weB, 1'b0);
    rst_n = 1'b1;
    mem_init = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i == 7) for (int r = 0; r < 4; r++) rcnt[r] = 0;
      step(tv[i]);
      if (i == 11) for (int r = 0; r < 4; r++) chk($sformatf("fair_rsp_count%0d", r), 128'(rcnt[r]), 128'd2);
    end
    chk("sb_drained", 128'(sb.size()), 128'd0);

`ifdef RAM_ARB_STATS_EN
    exp_grants = 0;
    for (int i = 0; i < 18; i++) exp_grants += $countones(tv[i].rdy);
    chk("stat_conflicts", stat_conflicts, 16'd1);
    chk("stat_grants", stat_grants, 16'(exp_grants));
`else
    exp_grants = 0;
`endif

    // Reset mid-flight: req 3 (port A) and req 0 (port B) reads granted, then reset.
    req_valid = 4'b1001;
    req_we    = 4'b0000;
    req_addr  = {10'd300, 10'd0, 10'd0, 10'd301};
    #1;
    chk("mid_ready", req_ready, 4'b1001);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("mid_rsp_valid", rsp_valid, 4'b0000);
    chk("mid_ready_rst", req_ready, 4'b0000);
    @(negedge clk);
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 4'b0000);
    chk("post_rst_rsp_rdata", rsp_rdata, '0);
    chk("post_rst_weA", weA, 1'b0);
    chk("post_rst_weB", weB, 1'b0);
`ifdef RAM_ARB_STATS_EN
    chk("post_rst_stat_grants", stat_grants, 16'd0);
`endif
    $display("[TB] mid-flight reset applied, grants before reset=%0d", exp_grants);
    rst_n = 1'b1;
    exp_rdata = '0;
    sb.delete();

    // Pointer must restart at 0: all-valid grants {0,1}.
    step(tv[18]);
    step(tv[19]);
    step(tv[19]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
